// File: rtl/instr_encoder_pkg.sv
// Shared CPU types for the instruction encoder slice.
// Contents:
//   opcode_t / funct_t / regbits_t / word_t : MIPS field and word types
//   RTYPE / J / JAL                         : opcodes that select the R and J formats
//   ramstate_t                              : RAM handshake status (FREE, BUSY, ACCESS, ERROR)
//   enc_state_t + IDLE/WRITE/ERR            : encoder FSM state encoding
//   encode_instr()                          : packs fields into a 32-bit instruction word
package instr_encoder_pkg;

    typedef logic [5:0]  opcode_t;
    typedef logic [5:0]  funct_t;
    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;

    localparam opcode_t RTYPE = 6'b000000;
    localparam opcode_t J     = 6'b000010;
    localparam opcode_t JAL   = 6'b000011;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Plain localparam encoding keeps the state compatible with older tools.
    typedef logic [1:0] enc_state_t;
    localparam enc_state_t IDLE  = 2'd0;
    localparam enc_state_t WRITE = 2'd1;
    localparam enc_state_t ERR   = 2'd2;

    // Selects R, J or I format from the opcode; fields outside the chosen
    // format are dropped.
    function automatic word_t encode_instr(
        input opcode_t     op,
        input regbits_t    rs,
        input regbits_t    rt,
        input regbits_t    rd,
        input logic [4:0]  shamt,
        input funct_t      funct,
        input logic [15:0] imm,
        input logic [25:0] addr
    );
        word_t w;
        if (op == RTYPE) begin
            w = {op, rs, rt, rd, shamt, funct};
        end else if (op == J || op == JAL) begin
            w = {op, addr};
        end else begin
            w = {op, rs, rt, imm};
        end
        return w;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-producer and RAM-write bus of the instruction encoder.
// slave  : the encoder's view (fields and ramstate in; in_ready, RAM write and status out)
// master : the producer/RAM environment's view (directions reversed)
interface instr_encoder_if
    import instr_encoder_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    logic             in_valid;
    logic             in_ready;
    opcode_t          opcode;
    regbits_t         rs;
    regbits_t         rt;
    regbits_t         rd;
    logic [4:0]       shamt;
    funct_t           funct;
    logic [15:0]      imm;
    logic [25:0]      addr;
    logic             base_load;
    word_t            base_addr;
    logic             ramWEN;
    word_t            ramaddr;
    word_t            ramstore;
    ramstate_t        ramstate;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] words_written;

    modport slave (
        input  in_valid, opcode, rs, rt, rd, shamt, funct, imm, addr,
               base_load, base_addr, ramstate,
        output in_ready, ramWEN, ramaddr, ramstore, busy, err, words_written
    );

    modport master (
        output in_valid, opcode, rs, rt, rd, shamt, funct, imm, addr,
               base_load, base_addr, ramstate,
        input  in_ready, ramWEN, ramaddr, ramstore, busy, err, words_written
    );

endinterface

// File: rtl/instr_encoder_word_fifo.sv
// Small synchronous FIFO holding encoded instruction words.
// Ports:
//   clk, rst         : clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_data   : write request and word (ignored when full)
//   i_pop            : drop the head word (ignored when empty)
//   o_data           : current head word (undefined content when empty)
//   o_full, o_empty  : occupancy flags
//   o_count          : number of stored words
module word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rdPtr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage carries no reset; validity is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs MIPS instruction fields into 32-bit words, buffers them in a word
// FIFO and writes them to sequential RAM addresses over the RAM handshake.
// Ports:
//   CLK, RST : clock, synchronous active-high reset
//   bus      : instr_encoder_if slave -- field bundle handshake (in_valid/in_ready
//              plus opcode/rs/rt/rd/shamt/funct/imm/addr), base_load/base_addr,
//              RAM write (ramWEN/ramaddr/ramstore, ramstate) and status
//              (busy, sticky err, words_written)
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic     CLK,
    input  logic     RST,
    instr_encoder_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    enc_state_t       r_state;
    word_t            r_wptr;
    logic [CNT_W-1:0] r_wordsWritten;
    logic             r_err;

    word_t            w_encoded;
    word_t            w_head;
    word_t            w_baseAligned;
    logic             w_full;
    logic             w_empty;
    logic [AW:0]      w_count;
    logic             w_push;
    logic             w_pop;

    assign w_encoded = encode_instr(bus.opcode, bus.rs, bus.rt, bus.rd,
                                    bus.shamt, bus.funct, bus.imm, bus.addr);

    assign w_baseAligned = bus.base_addr & ~32'h3;

    // A full FIFO refuses pushes even when the head is popped on the same edge.
    assign bus.in_ready = !w_full && (r_state != ERR);
    assign w_push       = bus.in_valid && bus.in_ready;
    assign w_pop        = (r_state == WRITE) && (bus.ramstate == ACCESS);

    word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_encoded),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Write FSM plus the address and completed-write counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state        <= IDLE;
            r_wptr         <= '0;
            r_wordsWritten <= '0;
            r_err          <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.base_load && w_empty) begin
                        r_wptr         <= w_baseAligned;
                        r_wordsWritten <= '0;
                    end
                    if (!w_empty) begin
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    case (bus.ramstate)
                        ACCESS: begin
                            r_wptr         <= r_wptr + 32'd4;
                            r_wordsWritten <= r_wordsWritten + CNT_W'(1);
                            // Leave only when the popped word was the last one
                            // and nothing new arrives on this edge.
                            if (w_count == CNT_ONE && !w_push) begin
                                r_state <= IDLE;
                            end
                        end
                        ERROR: begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                ERR: begin
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ramWEN        = (r_state == WRITE);
    assign bus.ramaddr       = r_wptr;
    assign bus.ramstore      = w_empty ? 32'h0 : w_head;
    assign bus.busy          = !w_empty || (r_state == WRITE);
    assign bus.err           = r_err;
    assign bus.words_written = r_wordsWritten;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (DEPTH=4, CNT_W=16).
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 CLK = ~CLK;

    instr_encoder_if #(.CNT_W(16)) bus ();

    instr_encoder #(
        .DEPTH (4),
        .CNT_W (16)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Advance one edge and settle past it before driving or sampling.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic setIType(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [15:0] imm);
        bus.opcode = op; bus.rs = rs; bus.rt = rt; bus.imm = imm;
        bus.rd = 5'h1f; bus.shamt = 5'h1f; bus.funct = 6'h3f; bus.addr = 26'h2aaaaaa;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.base_load = 1'b0; bus.base_addr = '0;
        bus.ramstate = FREE; setIType(6'b0, 5'd0, 5'd0, 16'h0);
        RST = 1'b1; tick(); tick(); RST = 1'b0;
        checks++; if (bus.ramWEN !== 1'b0) begin errors++; $display("[TB] FAIL reset_ramWEN got=%b exp=0", bus.ramWEN); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.ramaddr !== 32'h0) begin errors++; $display("[TB] FAIL reset_ramaddr got=%h exp=0", bus.ramaddr); end
        checks++; if (bus.ramstore !== 32'h0) begin errors++; $display("[TB] FAIL reset_ramstore got=%h exp=0", bus.ramstore); end
        checks++; if (bus.err !== 1'b0 || bus.words_written !== 16'd0) begin errors++; $display("[TB] FAIL reset_err_ww got=%b/%0d exp=0/0", bus.err, bus.words_written); end
    endtask

    task automatic test_itype_stall();
        bus.base_load = 1'b1; bus.base_addr = 32'h0000_0103;
        tick();
        bus.base_load = 1'b0;
        checks++; if (bus.ramaddr !== 32'h100) begin errors++; $display("[TB] FAIL base_load_addr got=%h exp=00000100", bus.ramaddr); end
        bus.ramstate = BUSY;
        setIType(6'b001001, 5'd0, 5'd1, 16'h0005);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.ramWEN !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL itype_edgeN got wen=%b busy=%b exp wen=0 busy=1", bus.ramWEN, bus.busy); end
        checks++; if (bus.ramstore !== 32'h24010005) begin errors++; $display("[TB] FAIL itype_head got=%h exp=24010005", bus.ramstore); end
        for (int c = 0; c < 3; c++) begin
            if (c == 2) bus.ramstate = ACCESS;
            tick();
            if (c < 2) begin
                checks++;
                if (bus.ramWEN !== 1'b1 || bus.ramaddr !== 32'h100 || bus.ramstore !== 32'h24010005) begin
                    errors++; $display("[TB] FAIL itype_stall%0d got wen=%b addr=%h data=%h exp 1/00000100/24010005", c, bus.ramWEN, bus.ramaddr, bus.ramstore);
                end
            end
        end
        checks++; if (bus.ramWEN !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL itype_done got wen=%b busy=%b exp 0/0", bus.ramWEN, bus.busy); end
        checks++; if (bus.words_written !== 16'd1 || bus.ramaddr !== 32'h104) begin errors++; $display("[TB] FAIL itype_count got ww=%0d addr=%h exp 1/00000104", bus.words_written, bus.ramaddr); end
        bus.ramstate = FREE;
    endtask

    task automatic test_back_to_back();
        bus.ramstate = ACCESS;
        bus.base_load = 1'b1; bus.base_addr = 32'h100;
        bus.opcode = RTYPE; bus.rs = 5'd1; bus.rt = 5'd2; bus.rd = 5'd3; bus.shamt = 5'd0;
        bus.funct = 6'b100001; bus.imm = 16'hbeef; bus.addr = 26'h3ffffff;
        bus.in_valid = 1'b1;
        tick();
        bus.base_load = 1'b0;
        checks++; if (bus.ramaddr !== 32'h100 || bus.words_written !== 16'd0) begin errors++; $display("[TB] FAIL b2b_rebase got addr=%h ww=%0d exp 00000100/0", bus.ramaddr, bus.words_written); end
        bus.opcode = J; bus.addr = 26'h0000010; bus.rs = 5'd7; bus.rt = 5'd9; bus.imm = 16'h1234;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.ramWEN !== 1'b1 || bus.ramaddr !== 32'h100 || bus.ramstore !== 32'h00221821) begin errors++; $display("[TB] FAIL b2b_rtype got wen=%b addr=%h data=%h exp 1/00000100/00221821", bus.ramWEN, bus.ramaddr, bus.ramstore); end
        tick();
        checks++; if (bus.ramWEN !== 1'b1 || bus.ramaddr !== 32'h104 || bus.ramstore !== 32'h08000010) begin errors++; $display("[TB] FAIL b2b_jtype got wen=%b addr=%h data=%h exp 1/00000104/08000010", bus.ramWEN, bus.ramaddr, bus.ramstore); end
        tick();
        checks++; if (bus.ramWEN !== 1'b0 || bus.busy !== 1'b0 || bus.words_written !== 16'd2) begin errors++; $display("[TB] FAIL b2b_done got wen=%b busy=%b ww=%0d exp 0/0/2", bus.ramWEN, bus.busy, bus.words_written); end
        checks++; if (bus.ramaddr !== 32'h108) begin errors++; $display("[TB] FAIL b2b_next_addr got=%h exp=00000108", bus.ramaddr); end
        bus.ramstate = FREE;
    endtask

    task automatic test_fifo_full();
        logic [31:0] fullExp [5];
        fullExp = '{32'h20010011, 32'h20020012, 32'h20030013, 32'h20040014, 32'h20050015};
        bus.ramstate = BUSY;
        for (int k = 1; k <= 4; k++) begin
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_ready_before%0d got=%b exp=1", k, bus.in_ready); end
            setIType(6'b001000, 5'd0, 5'(k), 16'h0010 + 16'(k));
            bus.in_valid = 1'b1;
            tick();
        end
        setIType(6'b001000, 5'd0, 5'd5, 16'h0015);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready_after4 got=%b exp=0", bus.in_ready); end
        tick();
        checks++; if (bus.in_ready !== 1'b0 || bus.ramstore !== fullExp[0] || bus.ramaddr !== 32'h108) begin errors++; $display("[TB] FAIL full_hold got rdy=%b data=%h addr=%h exp 0/%h/00000108", bus.in_ready, bus.ramstore, bus.ramaddr, fullExp[0]); end
        bus.ramstate = ACCESS;
        tick();
        checks++; if (bus.in_ready !== 1'b1 || bus.ramstore !== fullExp[1] || bus.words_written !== 16'd3) begin errors++; $display("[TB] FAIL full_pop_nopush got rdy=%b data=%h ww=%0d exp 1/%h/3", bus.in_ready, bus.ramstore, bus.words_written, fullExp[1]); end
        bus.ramstate = BUSY;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_refill got rdy=%b exp=0", bus.in_ready); end
        bus.ramstate = ACCESS;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (bus.ramWEN !== 1'b1 || bus.ramstore !== fullExp[k] || bus.ramaddr !== 32'h10C + 32'(4*(k-1))) begin
                errors++; $display("[TB] FAIL full_order%0d got wen=%b data=%h addr=%h exp 1/%h/%h", k, bus.ramWEN, bus.ramstore, bus.ramaddr, fullExp[k], 32'h10C + 32'(4*(k-1)));
            end
            tick();
        end
        checks++; if (bus.ramWEN !== 1'b0 || bus.busy !== 1'b0 || bus.words_written !== 16'd7 || bus.ramaddr !== 32'h11C) begin errors++; $display("[TB] FAIL full_drained got wen=%b busy=%b ww=%0d addr=%h exp 0/0/7/0000011c", bus.ramWEN, bus.busy, bus.words_written, bus.ramaddr); end
        bus.ramstate = FREE;
    endtask

    task automatic test_error();
        bus.opcode = JAL; bus.addr = 26'h3ffffff; bus.rs = 5'd4; bus.rt = 5'd5; bus.imm = 16'h0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        checks++; if (bus.ramWEN !== 1'b1 || bus.ramstore !== 32'h0fffffff || bus.ramaddr !== 32'h11C) begin errors++; $display("[TB] FAIL err_jal got wen=%b data=%h addr=%h exp 1/0fffffff/0000011c", bus.ramWEN, bus.ramstore, bus.ramaddr); end
        bus.ramstate = ERROR;
        tick();
        checks++; if (bus.err !== 1'b1 || bus.ramWEN !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL err_enter got err=%b wen=%b rdy=%b exp 1/0/0", bus.err, bus.ramWEN, bus.in_ready); end
        checks++; if (bus.words_written !== 16'd7 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL err_count got ww=%0d busy=%b exp 7/1", bus.words_written, bus.busy); end
        bus.ramstate = ACCESS; bus.in_valid = 1'b1;
        tick(); tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.err !== 1'b1 || bus.ramWEN !== 1'b0 || bus.in_ready !== 1'b0 || bus.words_written !== 16'd7) begin errors++; $display("[TB] FAIL err_sticky got err=%b wen=%b rdy=%b ww=%0d exp 1/0/0/7", bus.err, bus.ramWEN, bus.in_ready, bus.words_written); end
        bus.ramstate = FREE;
        RST = 1'b1; tick(); RST = 1'b0;
        checks++; if (bus.err !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.ramWEN !== 1'b0) begin errors++; $display("[TB] FAIL err_reset got err=%b rdy=%b busy=%b wen=%b exp 0/1/0/0", bus.err, bus.in_ready, bus.busy, bus.ramWEN); end
        checks++; if (bus.ramaddr !== 32'h0 || bus.ramstore !== 32'h0 || bus.words_written !== 16'd0) begin errors++; $display("[TB] FAIL err_reset_regs got addr=%h data=%h ww=%0d exp 0/0/0", bus.ramaddr, bus.ramstore, bus.words_written); end
    endtask

    task automatic test_base_load_busy();
        bus.ramstate = BUSY;
        setIType(6'b100011, 5'd2, 5'd3, 16'hfffc);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        checks++; if (bus.ramWEN !== 1'b1 || bus.ramaddr !== 32'h0 || bus.ramstore !== 32'h8c43fffc) begin errors++; $display("[TB] FAIL bl_first got wen=%b addr=%h data=%h exp 1/00000000/8c43fffc", bus.ramWEN, bus.ramaddr, bus.ramstore); end
        bus.base_load = 1'b1; bus.base_addr = 32'h200; bus.ramstate = ACCESS;
        tick();
        bus.base_load = 1'b0; bus.ramstate = BUSY;
        checks++; if (bus.ramaddr !== 32'h4 || bus.words_written !== 16'd1 || bus.ramWEN !== 1'b0) begin errors++; $display("[TB] FAIL bl_ignored_write got addr=%h ww=%0d wen=%b exp 00000004/1/0", bus.ramaddr, bus.words_written, bus.ramWEN); end
        setIType(6'b101011, 5'd2, 5'd3, 16'h0004);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0; bus.base_load = 1'b1;
        tick();
        bus.base_load = 1'b0;
        checks++; if (bus.ramWEN !== 1'b1 || bus.ramaddr !== 32'h4 || bus.ramstore !== 32'hac430004 || bus.words_written !== 16'd1) begin errors++; $display("[TB] FAIL bl_ignored_pending got wen=%b addr=%h data=%h ww=%0d exp 1/00000004/ac430004/1", bus.ramWEN, bus.ramaddr, bus.ramstore, bus.words_written); end
        RST = 1'b1; tick(); RST = 1'b0;
        checks++; if (bus.ramWEN !== 1'b0 || bus.busy !== 1'b0 || bus.ramstore !== 32'h0 || bus.ramaddr !== 32'h0) begin errors++; $display("[TB] FAIL mid_write_reset got wen=%b busy=%b data=%h addr=%h exp 0/0/0/0", bus.ramWEN, bus.busy, bus.ramstore, bus.ramaddr); end
        bus.ramstate = FREE;
    endtask

    initial begin
        test_reset();
        test_itype_stall();
        test_back_to_back();
        test_fifo_full();
        test_error();
        test_base_load_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
